// File: rtl/bootdata_streamer_if.sv
// rtl/bootdata_streamer_if.sv - byte source and boot-word req/ack bundle
interface bootdata_streamer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;

  modport master (
    input  byte_in, byte_valid, host_bootdata_ack,
    output byte_ready, host_bootdata, host_bootdata_req
  );

  modport slave (
    output byte_in, byte_valid, host_bootdata_ack,
    input  byte_ready, host_bootdata, host_bootdata_req
  );
endinterface

// File: rtl/bootdata_streamer.sv
// rtl/bootdata_streamer.sv - packs host bytes into 32-bit boot words, sent by four-phase req/ack
module bootdata_streamer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     total_words,
  bootdata_streamer_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic {C_IDLE, C_RUN} c_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} o_state_t;

  c_state_t         r_c_state, w_c_next;
  o_state_t         r_o_state, w_o_next;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_accept_left;
  logic [31:0]      r_stage;
  logic [31:0]      r_data;
  logic [1:0]       r_byte_idx;
  logic             r_full;
  logic             r_done;
  logic             r_error;
  logic [15:0]      r_to_cnt;

  logic w_start, w_byte_ready, w_take_byte, w_in_hs, w_timeout;
  logic w_load, w_word_done, w_hs_entry;

  assign w_start      = (r_c_state == C_IDLE) && start;
  assign w_byte_ready = (r_c_state == C_RUN) && !r_error && !r_full && (r_accept_left != '0);
  assign w_take_byte  = w_byte_ready && bus.byte_valid;
  assign w_in_hs      = (r_o_state == O_REQ) || (r_o_state == O_REL);
  assign w_timeout    = (TIMEOUT != 0) && w_in_hs && (r_to_cnt == 16'(TIMEOUT));
  assign w_hs_entry   = (w_o_next != r_o_state) && ((w_o_next == O_REQ) || (w_o_next == O_REL));

  // Output FSM: req only rises while ack is low, so a stale ack in O_IDLE is ignored
  always_comb begin
    w_o_next    = r_o_state;
    w_load      = 1'b0;
    w_word_done = 1'b0;
    case (r_o_state)
      O_IDLE: begin
        if (r_full && !bus.host_bootdata_ack) begin
          w_o_next = O_REQ;
          w_load   = 1'b1;
        end
      end
      O_REQ: begin
        if (bus.host_bootdata_ack) w_o_next = O_REL;
      end
      O_REL: begin
        if (!bus.host_bootdata_ack) begin
          w_o_next    = O_IDLE;
          w_word_done = 1'b1;
        end
      end
      default: w_o_next = O_IDLE;
    endcase
    if (w_timeout) begin
      w_o_next    = O_IDLE;
      w_word_done = 1'b0;
    end
  end

  always_comb begin
    w_c_next = r_c_state;
    case (r_c_state)
      C_IDLE: begin
        if (start && (total_words != '0)) w_c_next = C_RUN;
      end
      C_RUN: begin
        if (w_timeout) w_c_next = C_IDLE;
        else if (w_word_done && (r_remaining == CNT_W'(1))) w_c_next = C_IDLE;
      end
      default: w_c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_state <= C_IDLE;
      r_o_state <= O_IDLE;
    end else begin
      r_c_state <= w_c_next;
      r_o_state <= w_o_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining   <= '0;
      r_accept_left <= '0;
      r_stage       <= '0;
      r_data        <= '0;
      r_byte_idx    <= '0;
      r_full        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      if (w_start) begin
        r_remaining   <= total_words;
        r_accept_left <= total_words;
        r_done        <= (total_words == '0);
        r_error       <= 1'b0;
        r_full        <= 1'b0;
        r_byte_idx    <= '0;
      end else if (w_timeout) begin
        r_error    <= 1'b1;
        r_full     <= 1'b0;
        r_byte_idx <= '0;
      end else begin
        if (w_load) begin
          r_data <= r_stage;
          r_full <= 1'b0;
        end
        if (w_take_byte) begin
          r_stage[8*r_byte_idx +: 8] <= bus.byte_in;
          r_byte_idx                 <= r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            r_full        <= 1'b1;
            r_accept_left <= r_accept_left - 1'b1;
          end
        end
        if (w_word_done) begin
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == CNT_W'(1)) r_done <= 1'b1;
        end
      end

      // Per-phase watchdog: restarts on each handshake state entry, saturates
      if (w_hs_entry) r_to_cnt <= '0;
      else if (w_in_hs && (r_to_cnt != 16'hFFFF)) r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign bus.byte_ready        = w_byte_ready;
  assign bus.host_bootdata     = r_data;
  assign bus.host_bootdata_req = (r_o_state == O_REQ);
  assign busy                  = (r_c_state == C_RUN);
  assign done                  = r_done;
  assign error                 = r_error;

endmodule

// File: tb/tb_bootdata_streamer.sv
// tb/tb_bootdata_streamer.sv - scoreboard bench for bootdata_streamer
module tb_bootdata_streamer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] total_words;
  logic        busy, done, error;

  bootdata_streamer_if bus ();

  bootdata_streamer #(.CNT_W(16), .TIMEOUT(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .total_words (total_words),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          req_rises = 0;
  int          hs_done = 0;
  int          rise_dly = 3;
  int          fall_dly = 2;
  bit          ack_en = 1'b1;
  logic [31:0] exp_q[$];
  logic [7:0]  src[$];
  logic [31:0] pend;
  int          pcnt = 0;

  // Core model: raises ack rise_dly cycles into req, drops it fall_dly cycles after req falls
  initial begin
    int cnt;
    cnt = 0;
    bus.host_bootdata_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.host_bootdata_ack = 1'b0;
        cnt = 0;
      end else if (!bus.host_bootdata_ack) begin
        if (bus.host_bootdata_req && ack_en) begin
          cnt++;
          if (cnt >= rise_dly) begin bus.host_bootdata_ack = 1'b1; cnt = 0; end
        end else cnt = 0;
      end else if (!bus.host_bootdata_req) begin
        cnt++;
        if (cnt >= fall_dly) begin bus.host_bootdata_ack = 1'b0; cnt = 0; end
      end
    end
  end

  // Handshake monitor and scoreboard pop
  initial begin
    logic        prev_req, prev_ack;
    logic [31:0] prev_data, w;
    prev_req = 1'b0; prev_ack = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.host_bootdata_req && !prev_req) begin
          req_rises++;
          checks++;
          if (prev_ack !== 1'b0) begin
            failures++; $display("FAIL req_rise_with_ack got_ack=%b exp=0", prev_ack);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL unexpected_word got=%h exp=none", bus.host_bootdata);
          end else begin
            w = exp_q.pop_front();
            if (bus.host_bootdata !== w) begin
              failures++; $display("FAIL word_data got=%h exp=%h", bus.host_bootdata, w);
            end
          end
        end
        if (bus.host_bootdata_req && prev_req) begin
          checks++;
          if (bus.host_bootdata !== prev_data) begin
            failures++; $display("FAIL data_stable got=%h exp=%h", bus.host_bootdata, prev_data);
          end
        end
        if (prev_req && prev_ack) begin
          checks++;
          if (bus.host_bootdata_req !== 1'b0) begin
            failures++; $display("FAIL req_drop_on_ack got=%b exp=0", bus.host_bootdata_req);
          end
        end
        if (prev_req && !prev_ack && !error) begin
          checks++;
          if (bus.host_bootdata_req !== 1'b1) begin
            failures++; $display("FAIL req_hold got=%b exp=1", bus.host_bootdata_req);
          end
        end
        if (prev_ack && !bus.host_bootdata_ack) hs_done++;
        prev_req  = bus.host_bootdata_req;
        prev_ack  = bus.host_bootdata_ack;
        prev_data = bus.host_bootdata;
      end else begin
        prev_req = 1'b0; prev_ack = 1'b0; prev_data = '0;
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    src.delete();
    pcnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    src.push_back(b);
    pend[8*pcnt +: 8] = b;
    pcnt++;
    if (pcnt == 4) begin exp_q.push_back(pend); pcnt = 0; end
  endtask

  task automatic start_xfer(input int n);
    @(negedge clk);
    start = 1'b1;
    total_words = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input bit rnd, output int acc);
    int  cyc;
    bit  v;
    acc = 0;
    cyc = 0;
    while (src.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_valid = v;
      bus.byte_in    = src[0];
      #1;
      if (v && bus.byte_ready) begin void'(src.pop_front()); acc++; end
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done && c < 1000) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s_done_timeout got=%b exp=1", name, done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_after_done got=%b exp=0", name, busy); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL %s_words_left got=%0d exp=0", name, exp_q.size()); end
  endtask

  task automatic hold_valid_no_accept(input string name);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hEE;
      #1;
      if (bus.byte_ready) bad = 1'b1;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    checks++;
    if (bad) begin failures++; $display("FAIL %s_extra_byte got=ready exp=no_ready", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, bus.host_bootdata_req, bus.byte_ready} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000",
        {busy, done, error, bus.host_bootdata_req, bus.byte_ready});
    end
    checks++;
    if (bus.host_bootdata !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=00000000", bus.host_bootdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    int acc, hs0;
    clear_sb();
    rise_dly = 3; fall_dly = 2; ack_en = 1'b1;
    hs0 = hs_done;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    start_xfer(1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    send_bytes(1'b0, acc);
    checks++;
    if (acc != 4) begin failures++; $display("FAIL single_accepted got=%0d exp=4", acc); end
    checks++;
    if ({bus.byte_ready, bus.host_bootdata_req} !== 2'b00) begin
      failures++; $display("FAIL single_after_4th got=%b exp=00", {bus.byte_ready, bus.host_bootdata_req});
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.host_bootdata_req !== 1'b1) begin
      failures++; $display("FAIL single_req_latency got=%b exp=1", bus.host_bootdata_req);
    end
    wait_done("single");
    checks++;
    if (bus.host_bootdata_ack !== 1'b0) begin
      failures++; $display("FAIL single_done_before_ack_fall got=%b exp=0", bus.host_bootdata_ack);
    end
    checks++;
    if (bus.host_bootdata !== 32'h44332211) begin
      failures++; $display("FAIL single_hold_data got=%h exp=44332211", bus.host_bootdata);
    end
    checks++;
    if (hs_done - hs0 != 1) begin failures++; $display("FAIL single_handshakes got=%0d exp=1", hs_done - hs0); end
  endtask

  task automatic test_overlap();
    int acc, hs0;
    clear_sb();
    rise_dly = 10; fall_dly = 10; ack_en = 1'b1;
    hs0 = hs_done;
    for (int i = 0; i < 12; i++) push_byte(8'(i));
    start_xfer(3);
    send_bytes(1'b0, acc);
    checks++;
    if (acc != 12) begin failures++; $display("FAIL overlap_accepted got=%0d exp=12", acc); end
    checks++;
    if (hs_done - hs0 > 1) begin
      failures++; $display("FAIL overlap_refill got_handshakes=%0d exp_max=1", hs_done - hs0);
    end
    hold_valid_no_accept("overlap");
    wait_done("overlap");
    checks++;
    if (hs_done - hs0 != 3) begin failures++; $display("FAIL overlap_handshakes got=%0d exp=3", hs_done - hs0); end
  endtask

  task automatic test_stalls();
    int acc, hs0;
    clear_sb();
    rise_dly = 1; fall_dly = 4; ack_en = 1'b1;
    hs0 = hs_done;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    start_xfer(4);
    send_bytes(1'b1, acc);
    checks++;
    if (acc != 16) begin failures++; $display("FAIL stalls_accepted got=%0d exp=16", acc); end
    wait_done("stalls");
    checks++;
    if (hs_done - hs0 != 4) begin failures++; $display("FAIL stalls_handshakes got=%0d exp=4", hs_done - hs0); end
  endtask

  task automatic test_timeout();
    int acc, c, hi;
    clear_sb();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    start_xfer(2);
    send_bytes(1'b0, acc);
    c = 0;
    while (!bus.host_bootdata_req && c < 50) begin @(negedge clk); c++; end
    hi = 0;
    while (bus.host_bootdata_req && hi < 100) begin @(negedge clk); hi++; end
    checks++;
    if (hi < 20 || hi > 21) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=20..21", hi); end
    checks++;
    if ({error, busy, bus.host_bootdata_req, bus.byte_ready, done} !== 5'b10000) begin
      failures++; $display("FAIL timeout_flags got=%b exp=10000",
        {error, busy, bus.host_bootdata_req, bus.byte_ready, done});
    end
    clear_sb();
    ack_en = 1'b1; rise_dly = 2; fall_dly = 2;
    for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
    start_xfer(1);
    checks++;
    if ({error, busy} !== 2'b01) begin failures++; $display("FAIL timeout_restart got=%b exp=01", {error, busy}); end
    send_bytes(1'b0, acc);
    wait_done("timeout_recover");
    checks++;
    if (bus.host_bootdata !== 32'hD3D2D1D0) begin
      failures++; $display("FAIL timeout_recover_data got=%h exp=d3d2d1d0", bus.host_bootdata);
    end
  endtask

  task automatic test_zero_ignore();
    int acc, r0, hs0;
    clear_sb();
    rise_dly = 2; fall_dly = 2; ack_en = 1'b1;
    r0 = req_rises;
    start_xfer(0);
    checks++;
    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL zero_done got=%b exp=10", {done, busy}); end
    repeat (5) @(negedge clk);
    checks++;
    if (req_rises != r0) begin failures++; $display("FAIL zero_no_req got=%0d exp=%0d", req_rises, r0); end
    hs0 = hs_done;
    for (int i = 0; i < 8; i++) push_byte(8'h50 + 8'(i));
    start_xfer(2);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL ignore_done_cleared got=%b exp=0", done); end
    start_xfer(5);
    send_bytes(1'b0, acc);
    checks++;
    if (acc != 8) begin failures++; $display("FAIL ignore_accepted got=%0d exp=8", acc); end
    hold_valid_no_accept("ignore");
    wait_done("ignore");
    checks++;
    if (hs_done - hs0 != 2) begin failures++; $display("FAIL ignore_handshakes got=%0d exp=2", hs_done - hs0); end
  endtask

  task automatic test_async_reset();
    int acc, c;
    clear_sb();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
    start_xfer(2);
    send_bytes(1'b0, acc);
    c = 0;
    while (!bus.host_bootdata_req && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    checks++;
    if (bus.host_bootdata_req !== 1'b1) begin
      failures++; $display("FAIL areset_pre_req got=%b exp=1", bus.host_bootdata_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.host_bootdata_req, busy, bus.byte_ready, done, error} !== 5'b0) begin
      failures++; $display("FAIL areset_flags got=%b exp=00000",
        {bus.host_bootdata_req, busy, bus.byte_ready, done, error});
    end
    checks++;
    if (bus.host_bootdata !== 32'h0) begin
      failures++; $display("FAIL areset_data got=%h exp=00000000", bus.host_bootdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_sb();
    ack_en = 1'b1; rise_dly = 2; fall_dly = 2;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin failures++; $display("FAIL areset_idle got=%b exp=00", {busy, done}); end
    for (int i = 0; i < 4; i++) push_byte(8'h80 + 8'(i));
    start_xfer(1);
    send_bytes(1'b0, acc);
    wait_done("areset_after");
    checks++;
    if (bus.host_bootdata !== 32'h83828180) begin
      failures++; $display("FAIL areset_after_data got=%h exp=83828180", bus.host_bootdata);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    total_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_in = '0;
    test_reset();
    test_single_word();
    test_overlap();
    test_stalls();
    test_timeout();
    test_zero_ignore();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
